// File: rtl/freq_gate_ctrl_if.sv
// Control and status bundle between the frequency-meter sequencer and its counter/latch/display path.
// The sequencer takes the slave side. The host or the test environment takes the master side.
interface freq_gate_ctrl_if;
  logic       run;
  logic       single;
  logic       abort;
  logic       cnt_ovf;
  logic       cnt_clr;
  logic       cnt_en;
  logic       latch_en;
  logic       meas_done;
  logic       busy;
  logic       ovf;
  logic [7:0] meas_id;

  modport master (
    output run, single, abort, cnt_ovf,
    input  cnt_clr, cnt_en, latch_en, meas_done, busy, ovf, meas_id
  );

  modport slave (
    input  run, single, abort, cnt_ovf,
    output cnt_clr, cnt_en, latch_en, meas_done, busy, ovf, meas_id
  );
endinterface

// File: rtl/freq_gate_ctrl.sv
// Gate-time sequencer for the frequency meter: clear -> gate -> settle -> latch -> done.
// Every output is registered and decoded from the next state, so no input reaches an output combinationally.
module freq_gate_ctrl #(
  parameter int GATE_CYCLES   = 50_000_000,
  parameter int CLR_CYCLES    = 2,
  parameter int SETTLE_CYCLES = 4,
  localparam int TW           = $clog2(GATE_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  freq_gate_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    GATE   = 3'd2,
    SETTLE = 3'd3,
    LATCH  = 3'd4,
    DONE   = 3'd5
  } state_t;

  // The timer is sized for the gate period. CLR_CYCLES and SETTLE_CYCLES are expected to be no longer than that.
  localparam logic [TW-1:0] CLR_LAST    = TW'(CLR_CYCLES - 1);
  localparam logic [TW-1:0] GATE_LAST   = TW'(GATE_CYCLES - 1);
  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          ovf_pend_q, ovf_pend_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    meas_id_q, meas_id_d;
  logic          cnt_clr_q, cnt_clr_d;
  logic          cnt_en_q, cnt_en_d;
  logic          latch_en_q, latch_en_d;
  logic          meas_done_q, meas_done_d;
  logic          busy_q, busy_d;

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    ovf_pend_d = ovf_pend_q;
    ovf_d      = ovf_q;
    meas_id_d  = meas_id_q;

    if (state_q != IDLE && bus.abort) begin
      // Abort wins over every timer expiry and over a run-driven restart from DONE.
      state_d = IDLE;
      timer_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!bus.abort && (bus.run || bus.single)) begin
            state_d = CLEAR;
            timer_d = '0;
          end
        end
        CLEAR: begin
          if (timer_q == CLR_LAST) begin
            state_d = GATE;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        GATE: begin
          if (timer_q == GATE_LAST) begin
            state_d = SETTLE;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        SETTLE: begin
          if (timer_q == SETTLE_LAST) begin
            state_d = LATCH;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        LATCH: begin
          state_d   = DONE;
          ovf_d     = ovf_pend_q;
          meas_id_d = meas_id_q + 8'd1;
        end
        DONE: begin
          state_d = bus.run ? CLEAR : IDLE;
          timer_d = '0;
        end
        default: begin
          state_d = IDLE;
          timer_d = '0;
        end
      endcase
    end

    if ((state_q == GATE || state_q == SETTLE) && bus.cnt_ovf)
      ovf_pend_d = 1'b1;
    if (state_d == CLEAR)
      ovf_pend_d = 1'b0;

    cnt_clr_d   = (state_d == CLEAR);
    cnt_en_d    = (state_d == GATE);
    latch_en_d  = (state_d == LATCH);
    meas_done_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      ovf_pend_q  <= 1'b0;
      ovf_q       <= 1'b0;
      meas_id_q   <= 8'd0;
      cnt_clr_q   <= 1'b0;
      cnt_en_q    <= 1'b0;
      latch_en_q  <= 1'b0;
      meas_done_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      ovf_pend_q  <= ovf_pend_d;
      ovf_q       <= ovf_d;
      meas_id_q   <= meas_id_d;
      cnt_clr_q   <= cnt_clr_d;
      cnt_en_q    <= cnt_en_d;
      latch_en_q  <= latch_en_d;
      meas_done_q <= meas_done_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.cnt_clr   = cnt_clr_q;
  assign bus.cnt_en    = cnt_en_q;
  assign bus.latch_en  = latch_en_q;
  assign bus.meas_done = meas_done_q;
  assign bus.busy      = busy_q;
  assign bus.ovf       = ovf_q;
  assign bus.meas_id   = meas_id_q;

endmodule
